// File: rtl/exec_stage_mc.sv
// exec_stage_mc: registered execute stage with valid/ready handshake.
// Single-cycle ALU ops load the output register one edge after accept.
// DIVU/REMU run a restoring divider, one quotient bit per cycle, while
// the stage reports busy and refuses new work. Also produces the
// registered branch target (pc + low immediate bits).
module exec_stage_mc #(
  parameter int INST_MEM_WIDTH = 2,
  parameter int DATA_WIDTH     = 32
) (
  input  logic                      CLK,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [3:0]                ALUOp,
  input  logic [1:0]                ALUSrcs,
  input  logic [DATA_WIDTH-1:0]     op1,
  input  logic [DATA_WIDTH-1:0]     op2_reg,
  input  logic [15:0]               immediate,
  input  logic [4:0]                sa,
  input  logic [4:0]                rdist_in,
  input  logic                      RegWrite,
  input  logic                      MemWrite,
  input  logic                      MemRead,
  input  logic [INST_MEM_WIDTH-1:0] pc,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     alu_result,
  output logic [DATA_WIDTH-1:0]     store_data,
  output logic [4:0]                rdist,
  output logic                      RegWrite_next,
  output logic                      MemWrite_next,
  output logic                      MemRead_next,
  output logic [INST_MEM_WIDTH-1:0] branch_target,
  output logic                      busy
);

  localparam int SHW = $clog2(DATA_WIDTH);
  localparam int CW  = $clog2(DATA_WIDTH) + 1;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOR  = 4'd5;
  localparam logic [3:0] OP_SLT  = 4'd6;
  localparam logic [3:0] OP_SLTU = 4'd7;
  localparam logic [3:0] OP_SLL  = 4'd8;
  localparam logic [3:0] OP_SRL  = 4'd9;
  localparam logic [3:0] OP_SRA  = 4'd10;
  localparam logic [3:0] OP_LUI  = 4'd11;
  localparam logic [3:0] OP_DIVU = 4'd12;
  localparam logic [3:0] OP_REMU = 4'd13;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_DIV  = 1'b1
  } state_t;

  // FSM state
  state_t r_state;
  state_t w_state_next;

  // Output register
  logic                      r_out_valid;
  logic [DATA_WIDTH-1:0]     r_alu_result;
  logic [DATA_WIDTH-1:0]     r_store_data;
  logic [4:0]                r_rdist;
  logic                      r_regwrite;
  logic                      r_memwrite;
  logic                      r_memread;
  logic [INST_MEM_WIDTH-1:0] r_branch_target;

  // Divider working registers and the instruction context held while iterating
  logic [DATA_WIDTH-1:0]     r_rem;
  logic [DATA_WIDTH-1:0]     r_quo;
  logic [DATA_WIDTH-1:0]     r_divisor;
  logic [CW-1:0]             r_cnt;
  logic                      r_op_rem;
  logic [DATA_WIDTH-1:0]     r_pend_store;
  logic [4:0]                r_pend_rd;
  logic                      r_pend_regwrite;
  logic                      r_pend_memwrite;
  logic                      r_pend_memread;
  logic [INST_MEM_WIDTH-1:0] r_pend_bt;

  // Combinational nets
  logic [DATA_WIDTH-1:0]     w_b;
  logic [SHW-1:0]            w_shamt;
  logic [DATA_WIDTH-1:0]     w_alu;
  logic [INST_MEM_WIDTH-1:0] w_branch_target;
  logic                      w_busy;
  logic                      w_slot_free;
  logic                      w_accept;
  logic                      w_is_div;
  logic                      w_load_alu;
  logic                      w_div_accept;
  logic                      w_last_step;
  logic                      w_div_finish;
  logic [DATA_WIDTH:0]       w_rem_sh;
  logic [DATA_WIDTH:0]       w_trial;
  logic                      w_fits;
  logic [DATA_WIDTH-1:0]     w_rem_next;
  logic [DATA_WIDTH-1:0]     w_quo_next;
  logic [DATA_WIDTH-1:0]     w_div_result;

  // Handshake: accept only when idle and the output slot is free or draining
  assign w_slot_free  = !r_out_valid || out_ready;
  assign in_ready     = !w_busy && w_slot_free;
  assign w_accept     = in_valid && in_ready && !flush;
  assign w_is_div     = (ALUOp == OP_DIVU) || (ALUOp == OP_REMU);
  assign w_load_alu   = w_accept && !w_is_div;
  assign w_div_accept = w_accept && w_is_div;

  // The divide finishes on the final step, or later from the parked result
  // (counter 0) once the output slot frees up.
  assign w_last_step  = (r_state == S_DIV) && (r_cnt == CW'(1));
  assign w_div_finish = (r_state == S_DIV) &&
                        ((r_cnt == CW'(1)) || (r_cnt == '0)) && w_slot_free;

  assign w_branch_target = pc + immediate[INST_MEM_WIDTH-1:0];

  // Operand B select
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_b = op2_reg;
    case (ALUSrcs)
      2'b00:   w_b = op2_reg;
      2'b01:   w_b = DATA_WIDTH'(sa);
      2'b10:   w_b = DATA_WIDTH'($signed(immediate));
      default: w_b = DATA_WIDTH'(immediate);
    endcase
  end

  assign w_shamt = w_b[SHW-1:0];

  // Single-cycle ALU; divide opcodes are handled by the iterative path
  always_comb begin
    w_alu = '0;
    case (ALUOp)
      OP_ADD:  w_alu = op1 + w_b;
      OP_SUB:  w_alu = op1 - w_b;
      OP_AND:  w_alu = op1 & w_b;
      OP_OR:   w_alu = op1 | w_b;
      OP_XOR:  w_alu = op1 ^ w_b;
      OP_NOR:  w_alu = ~(op1 | w_b);
      OP_SLT:  w_alu = {{(DATA_WIDTH-1){1'b0}}, ($signed(op1) < $signed(w_b))};
      OP_SLTU: w_alu = {{(DATA_WIDTH-1){1'b0}}, (op1 < w_b)};
      OP_SLL:  w_alu = op1 << w_shamt;
      OP_SRL:  w_alu = op1 >> w_shamt;
      OP_SRA:  w_alu = $signed(op1) >>> w_shamt;
      OP_LUI:  w_alu = w_b << 16;
      default: w_alu = '0;
    endcase
  end

  // One restoring division step. The shifted partial remainder needs one
  // extra bit; the top bit of the trial difference is the borrow. A zero
  // divisor never borrows, so the quotient fills with ones and the
  // remainder ends up equal to the dividend.
  always_comb begin
    w_rem_sh   = {r_rem, r_quo[DATA_WIDTH-1]};
    w_trial    = w_rem_sh - {1'b0, r_divisor};
    w_fits     = !w_trial[DATA_WIDTH];
    w_rem_next = w_fits ? w_trial[DATA_WIDTH-1:0] : w_rem_sh[DATA_WIDTH-1:0];
    w_quo_next = {r_quo[DATA_WIDTH-2:0], w_fits};
  end

  // Divide result: straight from the final step, or from the parked registers
  always_comb begin
    w_div_result = '0;
    if (r_op_rem) w_div_result = w_last_step ? w_rem_next : r_rem;
    else          w_div_result = w_last_step ? w_quo_next : r_quo;
  end

  // FSM state register
  always_ff @(posedge CLK or posedge reset) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // FSM next-state logic; flush forces IDLE
  always_comb begin
    w_state_next = r_state;
    if (flush) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_div_accept) w_state_next = S_DIV;
        S_DIV:   if (w_div_finish) w_state_next = S_IDLE;
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    w_busy = 1'b0;
    if (r_state == S_DIV) w_busy = 1'b1;
  end

  assign busy = w_busy;

  // Divider datapath: latch operands and context on accept, then iterate
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_rem           <= '0;
      r_quo           <= '0;
      r_divisor       <= '0;
      r_cnt           <= '0;
      r_op_rem        <= 1'b0;
      r_pend_store    <= '0;
      r_pend_rd       <= '0;
      r_pend_regwrite <= 1'b0;
      r_pend_memwrite <= 1'b0;
      r_pend_memread  <= 1'b0;
      r_pend_bt       <= '0;
    end else if (w_div_accept) begin
      r_rem           <= '0;
      r_quo           <= op1;
      r_divisor       <= w_b;
      r_cnt           <= CW'(DATA_WIDTH);
      r_op_rem        <= (ALUOp == OP_REMU);
      r_pend_store    <= op2_reg;
      r_pend_rd       <= rdist_in;
      r_pend_regwrite <= RegWrite;
      r_pend_memwrite <= MemWrite;
      r_pend_memread  <= MemRead;
      r_pend_bt       <= w_branch_target;
    end else if ((r_state == S_DIV) && (r_cnt != '0)) begin
      r_rem <= w_rem_next;
      r_quo <= w_quo_next;
      r_cnt <= r_cnt - CW'(1);
    end
  end

  // Output register: flush kills, ALU or divide result loads, otherwise
  // a consumed entry drains and a stalled entry holds.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_out_valid     <= 1'b0;
      r_alu_result    <= '0;
      r_store_data    <= '0;
      r_rdist         <= '0;
      r_regwrite      <= 1'b0;
      r_memwrite      <= 1'b0;
      r_memread       <= 1'b0;
      r_branch_target <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
      r_regwrite  <= 1'b0;
      r_memwrite  <= 1'b0;
      r_memread   <= 1'b0;
    end else if (w_load_alu) begin
      r_out_valid     <= 1'b1;
      r_alu_result    <= w_alu;
      r_store_data    <= op2_reg;
      r_rdist         <= rdist_in;
      r_regwrite      <= RegWrite;
      r_memwrite      <= MemWrite;
      r_memread       <= MemRead;
      r_branch_target <= w_branch_target;
    end else if (w_div_finish) begin
      r_out_valid     <= 1'b1;
      r_alu_result    <= w_div_result;
      r_store_data    <= r_pend_store;
      r_rdist         <= r_pend_rd;
      r_regwrite      <= r_pend_regwrite;
      r_memwrite      <= r_pend_memwrite;
      r_memread       <= r_pend_memread;
      r_branch_target <= r_pend_bt;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid     = r_out_valid;
  assign alu_result    = r_alu_result;
  assign store_data    = r_store_data;
  assign rdist         = r_rdist;
  assign RegWrite_next = r_regwrite;
  assign MemWrite_next = r_memwrite;
  assign MemRead_next  = r_memread;
  assign branch_target = r_branch_target;

endmodule

// File: tb/tb_exec_stage_mc.sv
// Directed bench for exec_stage_mc: ALU vectors, divide latency and
// results, stall hold, streaming, flush mid-divide, async reset mid-divide.
module tb_exec_stage_mc;

  localparam int IW = 2;
  localparam int DW = 32;

  logic          CLK = 1'b0;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    ALUOp;
  logic [1:0]    ALUSrcs;
  logic [DW-1:0] op1;
  logic [DW-1:0] op2_reg;
  logic [15:0]   immediate;
  logic [4:0]    sa;
  logic [4:0]    rdist_in;
  logic          RegWrite;
  logic          MemWrite;
  logic          MemRead;
  logic [IW-1:0] pc;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] alu_result;
  logic [DW-1:0] store_data;
  logic [4:0]    rdist;
  logic          RegWrite_next;
  logic          MemWrite_next;
  logic          MemRead_next;
  logic [IW-1:0] branch_target;
  logic          busy;

  exec_stage_mc #(.INST_MEM_WIDTH(IW), .DATA_WIDTH(DW)) dut (
    .CLK           (CLK),
    .reset         (reset),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .ALUOp         (ALUOp),
    .ALUSrcs       (ALUSrcs),
    .op1           (op1),
    .op2_reg       (op2_reg),
    .immediate     (immediate),
    .sa            (sa),
    .rdist_in      (rdist_in),
    .RegWrite      (RegWrite),
    .MemWrite      (MemWrite),
    .MemRead       (MemRead),
    .pc            (pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .alu_result    (alu_result),
    .store_data    (store_data),
    .rdist         (rdist),
    .RegWrite_next (RegWrite_next),
    .MemWrite_next (MemWrite_next),
    .MemRead_next  (MemRead_next),
    .branch_target (branch_target),
    .busy          (busy)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [3:0]    op;
    logic [1:0]    srcs;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [15:0]   imm;
    logic [4:0]    sa;
    logic [DW-1:0] exp;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  task automatic drive(input logic [3:0] op, input logic [1:0] srcs,
                       input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [15:0] imm, input logic [4:0] s,
                       input logic [IW-1:0] pcv, input logic [4:0] rd);
    ALUOp     = op;
    ALUSrcs   = srcs;
    op1       = a;
    op2_reg   = b;
    immediate = imm;
    sa        = s;
    pc        = pcv;
    rdist_in  = rd;
    RegWrite  = 1'b1;
    in_valid  = 1'b1;
  endtask

  // Present one single-cycle op at a negedge and check it one cycle later
  task automatic alu_step(input logic [3:0] op, input logic [1:0] srcs,
                          input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [15:0] imm, input logic [4:0] s,
                          input logic [IW-1:0] pcv, input logic [DW-1:0] exp,
                          input string tag);
    logic [IW-1:0] bt;
    bt = pcv + imm[IW-1:0];
    drive(op, srcs, a, b, imm, s, pcv, 5'd3);
    @(posedge CLK);
    @(negedge CLK);
    in_valid = 1'b0;
    check({tag, " valid"}, 32'(out_valid), 32'd1);
    check({tag, " result"}, alu_result, exp);
    check({tag, " store"}, store_data, b);
    check({tag, " rd"}, 32'(rdist), 32'd3);
    check({tag, " bt"}, 32'(branch_target), 32'(bt));
  endtask

  // Divide with a full-latency check: busy/!in_ready/!out_valid for 32 cycles
  task automatic run_div(input logic [3:0] op, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input logic [DW-1:0] exp,
                         input string tag);
    int bad;
    drive(op, 2'b00, a, b, 16'h0000, 5'd0, 2'd1, 5'd9);
    @(posedge CLK);
    @(negedge CLK);
    in_valid = 1'b0;
    op1      = '0;
    op2_reg  = 32'hDEAD_BEEF;
    rdist_in = '0;
    bad = 0;
    for (int k = 0; k < DW; k++) begin
      if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) bad++;
      @(posedge CLK);
      @(negedge CLK);
    end
    check({tag, " busy window"}, 32'(bad), 32'd0);
    check({tag, " valid"}, 32'(out_valid), 32'd1);
    check({tag, " busy clr"}, 32'(busy), 32'd0);
    check({tag, " result"}, alu_result, exp);
    check({tag, " store"}, store_data, b);
    check({tag, " rd"}, 32'(rdist), 32'd9);
    check({tag, " bt"}, 32'(branch_target), 32'd1);
  endtask

  initial begin
    int bad;
    vecs = '{
      '{4'd0,  2'b00, 32'd5,          32'd7,          16'h0003, 5'd0,  32'd12},
      '{4'd0,  2'b10, 32'h7FFF_FFFF,  32'd0,          16'h0001, 5'd0,  32'h8000_0000},
      '{4'd1,  2'b00, 32'd3,          32'd5,          16'h0000, 5'd0,  32'hFFFF_FFFE},
      '{4'd2,  2'b00, 32'h0000_F0F0,  32'h0000_FF00,  16'h0000, 5'd0,  32'h0000_F000},
      '{4'd3,  2'b00, 32'h0000_F0F0,  32'h0000_0F0F,  16'h0000, 5'd0,  32'h0000_FFFF},
      '{4'd4,  2'b00, 32'h0000_FF00,  32'h0000_0FF0,  16'h0000, 5'd0,  32'h0000_F0F0},
      '{4'd5,  2'b00, 32'd0,          32'd0,          16'h0000, 5'd0,  32'hFFFF_FFFF},
      '{4'd6,  2'b00, 32'hFFFF_FFFF,  32'd1,          16'h0000, 5'd0,  32'd1},
      '{4'd7,  2'b00, 32'hFFFF_FFFF,  32'd1,          16'h0000, 5'd0,  32'd0},
      '{4'd8,  2'b01, 32'd1,          32'd0,          16'h0000, 5'd31, 32'h8000_0000},
      '{4'd9,  2'b01, 32'h8000_0000,  32'd0,          16'h0000, 5'd4,  32'h0800_0000},
      '{4'd10, 2'b01, 32'h8000_0000,  32'd0,          16'h0000, 5'd4,  32'hF800_0000},
      '{4'd11, 2'b11, 32'd0,          32'd0,          16'h1234, 5'd0,  32'h1234_0000},
      '{4'd0,  2'b10, 32'd10,         32'd0,          16'hFFFF, 5'd0,  32'd9},
      '{4'd0,  2'b11, 32'd10,         32'd0,          16'hFFFF, 5'd0,  32'h0001_0009},
      '{4'd8,  2'b00, 32'd1,          32'h0000_0021,  16'h0000, 5'd0,  32'd2},
      '{4'd15, 2'b00, 32'h0000_1234,  32'h0000_5678,  16'h0000, 5'd0,  32'd0}
    };

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    ALUOp = '0; ALUSrcs = '0; op1 = '0; op2_reg = '0; immediate = '0;
    sa = '0; rdist_in = '0; RegWrite = 1'b0; MemWrite = 1'b0; MemRead = 1'b0;
    pc = '0;

    #1;
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst result", alu_result, 32'd0);
    check("rst in_ready", 32'(in_ready), 32'd1);
    check("rst busy", 32'(busy), 32'd0);
    @(negedge CLK);
    reset = 1'b0;

    // ALU vectors streamed back to back
    for (int i = 0; i < NV; i++)
      alu_step(vecs[i].op, vecs[i].srcs, vecs[i].a, vecs[i].b, vecs[i].imm,
               vecs[i].sa, IW'(i), vecs[i].exp, $sformatf("alu%0d", i));

    // Divides, including divide by zero
    run_div(4'd12, 32'd100, 32'd7, 32'd14, "divu");
    run_div(4'd13, 32'd100, 32'd7, 32'd2, "remu");
    run_div(4'd12, 32'd9, 32'd0, 32'hFFFF_FFFF, "divu0");
    run_div(4'd13, 32'd9, 32'd0, 32'd9, "remu0");

    // Stall: result held for 5 cycles while a new op waits
    alu_step(4'd0, 2'b00, 32'd1, 32'd2, 16'h0000, 5'd0, 2'd0, 32'd3, "pre-stall");
    out_ready = 1'b0;
    drive(4'd0, 2'b00, 32'd10, 32'd20, 16'h0000, 5'd0, 2'd0, 5'd3);
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || alu_result !== 32'd3 ||
          store_data !== 32'd2 || rdist !== 5'd3) bad++;
      @(posedge CLK);
      @(negedge CLK);
    end
    check("stall hold", 32'(bad), 32'd0);
    check("stall in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    in_valid = 1'b0;
    check("release valid", 32'(out_valid), 32'd1);
    check("release result", alu_result, 32'd30);
    alu_step(4'd0, 2'b00, 32'd100, 32'd1, 16'h0001, 5'd0, 2'd2, 32'd101, "stream0");
    alu_step(4'd0, 2'b00, 32'd200, 32'd2, 16'h0001, 5'd0, 2'd2, 32'd202, "stream1");

    // Flush on the tenth cycle of a divide, with an op offered that cycle
    drive(4'd12, 2'b00, 32'd1000, 32'd3, 16'h0000, 5'd0, 2'd0, 5'd7);
    @(posedge CLK);
    @(negedge CLK);
    in_valid = 1'b0;
    for (int k = 0; k < 9; k++) begin
      @(posedge CLK);
      @(negedge CLK);
    end
    check("pre-flush busy", 32'(busy), 32'd1);
    check("pre-flush regwrite", 32'(RegWrite_next), 32'd1);
    flush = 1'b1;
    drive(4'd0, 2'b00, 32'd5, 32'd5, 16'h0000, 5'd0, 2'd0, 5'd1);
    @(posedge CLK);
    @(negedge CLK);
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush busy", 32'(busy), 32'd0);
    check("flush out_valid", 32'(out_valid), 32'd0);
    check("flush in_ready", 32'(in_ready), 32'd1);
    check("flush regwrite", 32'(RegWrite_next), 32'd0);

    // Asynchronous reset in the middle of a divide
    alu_step(4'd0, 2'b00, 32'd40, 32'd2, 16'h0001, 5'd0, 2'd2, 32'd42, "pre-rst");
    drive(4'd12, 2'b00, 32'd50, 32'd5, 16'h0000, 5'd0, 2'd0, 5'd7);
    @(posedge CLK);
    @(negedge CLK);
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge CLK);
      @(negedge CLK);
    end
    #2;
    reset = 1'b1;
    #1;
    check("arst busy", 32'(busy), 32'd0);
    check("arst in_ready", 32'(in_ready), 32'd1);
    check("arst result", alu_result, 32'd0);
    check("arst store", store_data, 32'd0);
    check("arst bt", 32'(branch_target), 32'd0);
    check("arst regwrite", 32'(RegWrite_next), 32'd0);
    @(negedge CLK);
    reset = 1'b0;
    alu_step(4'd1, 2'b00, 32'd50, 32'd8, 16'h0002, 5'd0, 2'd3, 32'd42, "post-rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/exec_stage_mc.md
Name: exec_stage_mc

Overview:
Parametrised execute stage for the pipelined core: a registered ALU stage with a valid/ready handshake, downstream stall support, and flush. It adds an iterative unsigned divider (DIVU/REMU) that holds the stage for multiple cycles. It sits between decode/register-read and the memory stage, and also produces the branch target.

Parameters:
INST_MEM_WIDTH, 2, width of pc and branch_target
DATA_WIDTH, 32, operand/result width (power of two, >=8)

Ports:
CLK  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state
flush  in  1  synchronous kill of stage contents and in-flight divide
in_valid  in  1  upstream presents an instruction
in_ready  out  1  stage can accept this cycle
ALUOp  in  4  operation (encoding below)
ALUSrcs  in  2  operand B select: 00 op2_reg, 01 zero-ext sa, 10 sign-ext immediate, 11 zero-ext immediate
op1  in  DATA_WIDTH  operand A (rs value)
op2_reg  in  DATA_WIDTH  rt value; also store data
immediate  in  16  instruction immediate
sa  in  5  shift amount field
rdist_in  in  5  destination register, already selected
RegWrite, MemWrite, MemRead  in  1 each  control bits passed through
pc  in  INST_MEM_WIDTH  instruction pc
out_valid  out  1  result register holds a valid instruction
out_ready  in  1  downstream accepts; low = stall
alu_result  out  DATA_WIDTH  registered result
store_data  out  DATA_WIDTH  registered op2_reg
rdist  out  5  registered rdist_in
RegWrite_next, MemWrite_next, MemRead_next  out  1 each  registered control
branch_target  out  INST_MEM_WIDTH  registered pc + immediate[INST_MEM_WIDTH-1:0], mod 2^INST_MEM_WIDTH
busy  out  1  divider iterating

Behaviour:
- ALUOp: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT (signed), 7 SLTU, 8 SLL, 9 SRL, 10 SRA, 11 LUI (B<<16), 12 DIVU (quotient), 13 REMU (remainder), 14–15 give result 0.
- Shift ops shift A by B[$clog2(DATA_WIDTH)-1:0]. ADD/SUB wrap with no overflow trap. SLT/SLTU produce 0 or 1.
- in_ready = !busy && (!out_valid || out_ready), combinational. Accept = in_valid && in_ready.
- Single-cycle ops: on accept, all outputs load at the next edge and out_valid=1. Latency is 1 cycle.
- Divide FSM, states IDLE and DIV:
  - IDLE→DIV on accept of op 12/13. The stage latches dividend, divisor, op, controls, pc and immediate, loads counter=DATA_WIDTH, and asserts busy. out_valid drops at that same edge if downstream took the old entry; otherwise it holds.
  - DIV performs one restoring step per cycle and decrements the counter.
  - When the step with counter==1 completes, the output register loads the quotient or remainder, out_valid=1, busy=0, and the FSM returns to IDLE. Latency from accept to out_valid is DATA_WIDTH cycles.
  - A DIV result never overwrites an unconsumed out_valid entry. If out_valid && !out_ready at completion time, the FSM waits in DIV with counter=0 and busy=1 until the slot frees.
- Divide by zero: quotient is all ones, remainder is the dividend. Same latency as any other divide.
- Stall: while out_valid && !out_ready, every output holds its value bit-for-bit.
- Flush has priority over all but reset. At the next edge: out_valid=0, RegWrite_next/MemWrite_next/MemRead_next=0, FSM→IDLE, busy=0. in_valid in the flush cycle is ignored and nothing is accepted. Data outputs may keep stale values.
- Reset (asynchronous, any time including mid-divide): all outputs and registers 0, FSM=IDLE, busy=0, in_ready=1 immediately.
- out_valid && out_ready with a simultaneous accept: the new entry replaces the old one at the edge with no bubble.

Test Plan:
- Reset then ADD: op1=5, op2_reg=7, ALUSrcs=00 → one cycle later out_valid=1, alu_result=12. A second op1=0x7FFFFFFF + imm 1 (ALUSrcs=10) gives 0x80000000.
- SLT: op1=0xFFFFFFFF, B=1 → 1. SLTU with the same operands → 0. SRA: op1=0x80000000, sa=4 (ALUSrcs=01) → 0xF8000000.
- DIVU: op1=100, B=7, then REMU with the same operands → results 14 and 2. Each appears exactly 32 cycles after accept, with in_ready=0 and busy=1 throughout.
- Divide by zero: DIVU 9/0 → 0xFFFFFFFF; REMU 9/0 → 9.
- out_ready=0 for 5 cycles with a result held → outputs stable and in_ready=0. Release → back-to-back ADDs stream one per cycle.
- Flush at cycle 10 of a DIVU → next cycle busy=0, out_valid=0, in_ready=1. Then assert async reset mid-divide → outputs 0 before the next CLK edge.
